// File: rtl/frame_pkg.sv
// Shared types and constants for the frame checker: FSM states, error codes and framing sizes.
package frame_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_FCS  = 3'd3,
    S_DROP = 3'd4
  } state_e;

  localparam logic [1:0]  ERR_OK    = 2'd0;
  localparam logic [1:0]  ERR_FCS   = 2'd1;
  localparam logic [1:0]  ERR_LEN   = 2'd2;
  localparam logic [1:0]  ERR_ABORT = 2'd3;

  localparam logic [15:0] DEF_LEN_DEFAULT = 16'd64;
  localparam int unsigned FCS_BYTES       = 4;
  localparam logic [1:0]  FCS_LAST        = 2'(FCS_BYTES - 1);

endpackage

// File: rtl/frame_checker_if.sv
// Byte-stream bundle between frame identifier, frame checker and payload consumer.
interface frame_checker_if;
  logic [7:0]  din;
  logic        din_sop;
  logic        din_eop;
  logic        din_vld;
  logic [7:0]  dout;
  logic        dout_sop;
  logic        dout_eop;
  logic        dout_vld;
  logic [7:0]  frm_type;
  logic [15:0] frm_len;
  logic        frm_done;
  logic        frm_err;
  logic [1:0]  err_code;

  modport master (
    output din, din_sop, din_eop, din_vld,
    input  dout, dout_sop, dout_eop, dout_vld,
    input  frm_type, frm_len, frm_done, frm_err, err_code
  );

  modport slave (
    input  din, din_sop, din_eop, din_vld,
    output dout, dout_sop, dout_eop, dout_vld,
    output frm_type, frm_len, frm_done, frm_err, err_code
  );
endinterface

// File: rtl/frame_fcs_acc.sv
// Running 32-bit sum of payload bytes, used as the frame check value.
module frame_fcs_acc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  din_i,
  output logic [31:0] sum_o
);
  logic [31:0] sum_q;

  // Clear wins over accumulate so a new frame always starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= 32'd0;
    end else if (clr_i) begin
      sum_q <= 32'd0;
    end else if (en_i) begin
      sum_q <= sum_q + {24'd0, din_i};
    end else begin
      sum_q <= sum_q;
    end
  end

  assign sum_o = sum_q;
endmodule

// File: rtl/frame_checker.sv
// Strips TYPE/LEN/FCS from received frames, forwards payload and reports per-frame status.
// Checksum comparison is built only when FRAME_CHECKER_FCS_EN is defined.
module frame_checker
  import frame_pkg::*;
#(
  parameter logic [15:0] DEF_LEN = DEF_LEN_DEFAULT,
  parameter logic [15:0] MAX_LEN = 16'hFFFF
) (
  input logic            clk,
  input logic            rst_n,
  frame_checker_if.slave bus
);
  state_e      state_q;
  logic [15:0] cnt_q;
  logic        len_idx_q;
  logic [1:0]  fcs_cnt_q;
  logic [7:0]  dout_q;
  logic        dout_sop_q;
  logic        dout_eop_q;
  logic        dout_vld_q;
  logic [7:0]  frm_type_q;
  logic [15:0] frm_len_q;
  logic        frm_done_q;
  logic        frm_err_q;
  logic [1:0]  err_code_q;

  logic [15:0] len_nx_s;
  logic        len_over_s;
  logic        data_last_s;
  logic        fcs_ok_s;

  assign len_nx_s    = {frm_len_q[15:8], bus.din};
  assign data_last_s = (cnt_q == (frm_len_q - 16'd1));

  if (MAX_LEN == 16'hFFFF) begin : g_no_max
    assign len_over_s = 1'b0;
  end else begin : g_max
    assign len_over_s = (len_nx_s > MAX_LEN);
  end

`ifdef FRAME_CHECKER_FCS_EN
  logic [31:0] sum_s;
  logic [23:0] fcs_rx_q;
  logic        acc_clr_s;
  logic        acc_en_s;

  assign acc_clr_s = bus.din_vld & bus.din_sop;
  assign acc_en_s  = bus.din_vld & ~bus.din_sop & ~bus.din_eop & (state_q == S_DATA);

  frame_fcs_acc u_fcs_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (acc_clr_s),
    .en_i  (acc_en_s),
    .din_i (bus.din),
    .sum_o (sum_s)
  );

  // Holds the first three received FCS bytes; the fourth is compared straight off the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcs_rx_q <= 24'd0;
    end else if (bus.din_vld && !bus.din_sop && (state_q == S_FCS)) begin
      fcs_rx_q <= {fcs_rx_q[15:0], bus.din};
    end else begin
      fcs_rx_q <= fcs_rx_q;
    end
  end

  assign fcs_ok_s = ({fcs_rx_q, bus.din} == sum_s);
`else
  assign fcs_ok_s = 1'b1;
`endif

  task automatic close_frame(input logic [1:0] code);
    frm_done_q <= 1'b1;
    frm_err_q  <= (code != ERR_OK);
    err_code_q <= code;
  endtask

  // Frame parser FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 16'd0;
      len_idx_q  <= 1'b0;
      fcs_cnt_q  <= 2'd0;
      dout_q     <= 8'd0;
      dout_sop_q <= 1'b0;
      dout_eop_q <= 1'b0;
      dout_vld_q <= 1'b0;
      frm_type_q <= 8'd0;
      frm_len_q  <= 16'd0;
      frm_done_q <= 1'b0;
      frm_err_q  <= 1'b0;
      err_code_q <= ERR_OK;
    end else begin
      frm_done_q <= 1'b0;
      dout_vld_q <= 1'b0;
      dout_sop_q <= 1'b0;
      dout_eop_q <= 1'b0;
      if (bus.din_vld && bus.din_sop) begin
        // A sop always restarts parsing, closing any frame still in flight.
        frm_type_q <= bus.din;
        cnt_q      <= 16'd0;
        len_idx_q  <= 1'b0;
        fcs_cnt_q  <= 2'd0;
        if (state_q == S_LEN || state_q == S_DATA || state_q == S_FCS) begin
          close_frame(ERR_ABORT);
        end else if (bus.din_eop) begin
          close_frame(ERR_LEN);
        end
        if (bus.din_eop) begin
          state_q <= S_IDLE;
        end else if (bus.din == 8'd0) begin
          frm_len_q <= DEF_LEN;
          state_q   <= S_DATA;
        end else begin
          state_q <= S_LEN;
        end
      end else if (bus.din_vld) begin
        case (state_q)
          S_IDLE: begin
            state_q <= S_IDLE;
          end
          S_LEN: begin
            if (bus.din_eop) begin
              close_frame(ERR_LEN);
              state_q <= S_IDLE;
            end else if (!len_idx_q) begin
              frm_len_q <= {bus.din, frm_len_q[7:0]};
              len_idx_q <= 1'b1;
            end else begin
              frm_len_q <= len_nx_s;
              len_idx_q <= 1'b0;
              cnt_q     <= 16'd0;
              if (len_nx_s == 16'd0) begin
                state_q <= S_FCS;
              end else if (len_over_s) begin
                close_frame(ERR_LEN);
                state_q <= S_DROP;
              end else begin
                state_q <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (bus.din_eop) begin
              close_frame(ERR_LEN);
              state_q <= S_IDLE;
            end else begin
              dout_q     <= bus.din;
              dout_vld_q <= 1'b1;
              dout_sop_q <= (cnt_q == 16'd0);
              dout_eop_q <= data_last_s;
              if (data_last_s) begin
                cnt_q   <= 16'd0;
                state_q <= S_FCS;
              end else begin
                cnt_q <= cnt_q + 16'd1;
              end
            end
          end
          S_FCS: begin
            if (fcs_cnt_q == FCS_LAST) begin
              fcs_cnt_q <= 2'd0;
              if (bus.din_eop) begin
                close_frame(fcs_ok_s ? ERR_OK : ERR_FCS);
                state_q <= S_IDLE;
              end else begin
                close_frame(ERR_LEN);
                state_q <= S_DROP;
              end
            end else if (bus.din_eop) begin
              fcs_cnt_q <= 2'd0;
              close_frame(ERR_LEN);
              state_q <= S_IDLE;
            end else begin
              fcs_cnt_q <= fcs_cnt_q + 2'd1;
            end
          end
          S_DROP: begin
            if (bus.din_eop) begin
              state_q <= S_IDLE;
            end
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.dout     = dout_q;
  assign bus.dout_sop = dout_sop_q;
  assign bus.dout_eop = dout_eop_q;
  assign bus.dout_vld = dout_vld_q;
  assign bus.frm_type = frm_type_q;
  assign bus.frm_len  = frm_len_q;
  assign bus.frm_done = frm_done_q;
  assign bus.frm_err  = frm_err_q;
  assign bus.err_code = err_code_q;
endmodule
